// File: rtl/rom_reader_pkg.sv
// Shared constants and type definitions for the PROM scan reader.
// Chip geometry for the 556PT5 (3604) and 556PT4 (3601) parts, default
// operation codes and the reader / step-detector state encodings.
package rom_reader_pkg;

    // 556PT5 / 3604 geometry
    localparam int IP3604_DATA_WIDTH    = 8;
    localparam int IP3604_ADDRESS_WIDTH = 9;

    // 556PT4 / 3601 geometry
    localparam int IP3601_DATA_WIDTH    = 4;
    localparam int IP3601_ADDRESS_WIDTH = 8;

    // Operation lines V4..V1
    localparam logic [3:0] READ_OP_DEFAULT = 4'b1100;
    localparam logic [3:0] IDLE_OP_DEFAULT = 4'b0000;

    // Reader sequencing states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        NEXT    = 2'd3
    } reader_state_t;

    // Pending manual step direction
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_dir_t;

endpackage

// File: rtl/rom_scan_reader_if.sv
// Chip socket bundle: operation and address lines driven by the reader,
// data lines returned by the PROM.
interface rom_scan_reader_if
    import rom_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = IP3604_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH
);
    logic [3:0]               operation;
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [DATA_WIDTH-1:0]    data_line_in;

    // Reader side
    modport master (
        output operation,
        output address_line,
        input  data_line_in
    );

    // Chip / socket side
    modport slave (
        input  operation,
        input  address_line,
        output data_line_in
    );
endinterface

// File: rtl/rom_step_detector.sv
// Release-commit button decoder for manual address stepping.
// A press is exactly one of the two buttons high; the step is committed
// (one-cycle pulse) in the first cycle both buttons are low again.
// Both buttons high cancels the pending press. While arm is low everything
// is ignored, and after arm returns the detector waits for both buttons low
// before accepting a new press.
module rom_step_detector
    import rom_reader_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic increment_address,
    input  logic decrement_address,
    input  logic arm,
    output logic step_up,
    output logic step_down
);

    step_dir_t pending_reg;
    logic      locked_reg;

    logic both_low;
    logic both_high;

    assign both_low  = ~increment_address & ~decrement_address;
    assign both_high =  increment_address &  decrement_address;

    // Commit pulses fire in the release cycle itself
    assign step_up   = arm & ~locked_reg & both_low & (pending_reg == STEP_UP);
    assign step_down = arm & ~locked_reg & both_low & (pending_reg == STEP_DOWN);

    // Track the pending press and the lockout after cancel / disarm
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= STEP_NONE;
            locked_reg  <= 1'b1;
        end else if (!arm) begin
            pending_reg <= STEP_NONE;
            locked_reg  <= 1'b1;
        end else if (locked_reg) begin
            pending_reg <= STEP_NONE;
            if (both_low) begin
                locked_reg <= 1'b0;
            end
        end else if (both_high) begin
            pending_reg <= STEP_NONE;
            locked_reg  <= 1'b1;
        end else if (increment_address) begin
            pending_reg <= STEP_UP;
        end else if (decrement_address) begin
            pending_reg <= STEP_DOWN;
        end else begin
            pending_reg <= STEP_NONE;
        end
    end

endmodule

// File: rtl/rom_scan_reader.sv
// PROM reader for 556PT5 / 556PT4 class parts.
// Drives address and operation lines, waits ACCESS_CYCLES clocks, then
// captures the chip data with a one-cycle data_valid strobe. Supports
// manual step up/down (release-commit) and an automatic full-range scan.
// Optional feature macro: ROM_READER_CHECKSUM_EN adds a scan checksum output.
module rom_scan_reader
    import rom_reader_pkg::*;
#(
    parameter int         DATA_WIDTH    = IP3604_DATA_WIDTH,
    parameter int         ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH,
    parameter int         ACCESS_CYCLES = 4,
    parameter logic [3:0] READ_OP       = READ_OP_DEFAULT,
    parameter logic [3:0] IDLE_OP       = IDLE_OP_DEFAULT
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  increment_address,
    input  logic                  decrement_address,
    input  logic                  scan_start,
    rom_scan_reader_if.master     chip,
    output logic [DATA_WIDTH-1:0] data_line,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  scan_done
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH+ADDRESS_WIDTH-1:0] checksum
`endif
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST = '1;

    reader_state_t              state_reg;
    logic [3:0]                 op_reg;
    logic [ADDRESS_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]      data_reg;
    logic                       valid_reg;
    logic                       busy_reg;
    logic                       done_reg;
    logic                       scanning_reg;
    logic                       first_reg;
    logic [CNT_W-1:0]           cnt_reg;

    logic step_up;
    logic step_down;

    rom_step_detector u_step_detector (
        .clk               (clk),
        .reset             (reset),
        .increment_address (increment_address),
        .decrement_address (decrement_address),
        .arm               (~busy_reg),
        .step_up           (step_up),
        .step_down         (step_down)
    );

    // Read sequencer: IDLE -> ACCESS -> CAPTURE -> (IDLE | NEXT -> ACCESS ...)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            op_reg       <= IDLE_OP;
            addr_reg     <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            scanning_reg <= 1'b0;
            first_reg    <= 1'b1;
            cnt_reg      <= '0;
        end else begin
            op_reg    <= READ_OP;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            first_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (first_reg) begin
                        // automatic read of address 0 after reset
                        state_reg <= ACCESS;
                        busy_reg  <= 1'b1;
                    end else if (scan_start) begin
                        // scan takes priority over a same-cycle step commit
                        addr_reg     <= '0;
                        scanning_reg <= 1'b1;
                        state_reg    <= ACCESS;
                        busy_reg     <= 1'b1;
                    end else if (step_up) begin
                        addr_reg  <= addr_reg + ADDR_ONE;
                        state_reg <= ACCESS;
                        busy_reg  <= 1'b1;
                    end else if (step_down) begin
                        addr_reg  <= addr_reg - ADDR_ONE;
                        state_reg <= ACCESS;
                        busy_reg  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                CAPTURE: begin
                    data_reg  <= chip.data_line_in;
                    valid_reg <= 1'b1;
                    cnt_reg   <= '0;
                    if (scanning_reg) begin
                        state_reg <= NEXT;
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                NEXT: begin
                    cnt_reg <= '0;
                    if (addr_reg == ADDR_LAST) begin
                        done_reg     <= 1'b1;
                        scanning_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        addr_reg  <= addr_reg + ADDR_ONE;
                        state_reg <= ACCESS;
                    end
                end
            endcase
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    logic [DATA_WIDTH+ADDRESS_WIDTH-1:0] checksum_reg;

    // Running sum of scan captures; manual reads leave it untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_reg <= '0;
        end else if (state_reg == IDLE && !first_reg && scan_start) begin
            checksum_reg <= '0;
        end else if (state_reg == CAPTURE && scanning_reg) begin
            checksum_reg <= checksum_reg + (DATA_WIDTH + ADDRESS_WIDTH)'(chip.data_line_in);
        end
    end

    assign checksum = checksum_reg;
`endif

    assign chip.operation    = op_reg;
    assign chip.address_line = addr_reg;
    assign data_line         = data_reg;
    assign data_valid        = valid_reg;
    assign busy              = busy_reg;
    assign scan_done         = done_reg;

endmodule

// File: tb/tb_rom_scan_reader.sv
// Bench for rom_scan_reader: ROM model data = addr[7:0] ^ 8'hA5.
// Table of manual steps, random manual walk against an address model,
// full scans, and reset mid-scan.
module tb_rom_scan_reader;

    localparam int DW = 8;
    localparam int AW = 9;
    localparam int AC = 3;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic scan_start = 1'b0;
    logic [DW-1:0] data_line;
    logic data_valid;
    logic busy;
    logic scan_done;
`ifdef ROM_READER_CHECKSUM_EN
    logic [DW+AW-1:0] checksum;
`endif

    rom_scan_reader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) chip ();

    rom_scan_reader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .ACCESS_CYCLES (AC),
        .READ_OP       (4'b1100),
        .IDLE_OP       (4'b0000)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .increment_address (inc),
        .decrement_address (dec),
        .scan_start        (scan_start),
        .chip              (chip),
        .data_line         (data_line),
        .data_valid        (data_valid),
        .busy              (busy),
        .scan_done         (scan_done)
`ifdef ROM_READER_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    // ROM contents
    assign chip.data_line_in = chip.address_line[7:0] ^ 8'hA5;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int model_addr = 0;

    typedef struct {
        int           kind;      // 0 = inc, 1 = dec, 2 = cancel
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rom_data(input int a);
        return DW'((a % 256) ^ 8'hA5);
    endfunction

    // Reset pulse followed by the automatic read of address 0
    task automatic do_reset();
        int vcnt;
        int vat;
        int dcnt;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_operation", 32'(chip.operation), 32'h0);
        check("rst_address", 32'(chip.address_line), 32'h0);
        check("rst_data_line", 32'(data_line), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_scan_done", 32'(scan_done), 32'h0);
`ifdef ROM_READER_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'h0);
`endif
        reset = 1'b0;
        vcnt = 0; vat = 0; dcnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("post_rst_operation", 32'(chip.operation), 32'hC);
                check("post_rst_busy", 32'(busy), 32'h1);
            end
            if (scan_done) dcnt++;
            if (data_valid) begin
                vcnt++;
                vat = k;
                check("auto_read_data", 32'(data_line), 32'hA5);
                check("auto_read_addr", 32'(chip.address_line), 32'h0);
            end
        end
        check("auto_read_valid_count", 32'(vcnt), 32'd1);
        check("auto_read_latency", 32'(vat), 32'(AC + 2));
        check("post_rst_scan_done", 32'(dcnt), 32'd0);
        model_addr = 0;
    endtask

    // One manual press/release (or cancel) with latency and data checks
    task automatic do_step(input int kind, input logic [AW-1:0] exp_addr,
                           input logic [DW-1:0] exp_data, input int hold);
        int vcnt;
        int vat;
        @(negedge clk);
        if (kind == 1) dec = 1'b1;
        else inc = 1'b1;
        repeat (hold) @(negedge clk);
        if (kind == 2) begin
            dec = 1'b1;
            repeat (2) @(negedge clk);
        end
        inc = 1'b0;
        dec = 1'b0;
        vcnt = 0; vat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1 && kind != 2) begin
                check("step_addr_t1", 32'(chip.address_line), 32'(exp_addr));
                check("step_busy_t1", 32'(busy), 32'h1);
            end
            if (data_valid) begin
                vcnt++;
                vat = k;
                check("step_data", 32'(data_line), 32'(exp_data));
            end
        end
        check("step_final_addr", 32'(chip.address_line), 32'(exp_addr));
        check("step_final_data", 32'(data_line), 32'(exp_data));
        check("step_busy_idle", 32'(busy), 32'h0);
        if (kind == 2) begin
            check("cancel_valid_count", 32'(vcnt), 32'd0);
        end else begin
            check("step_valid_count", 32'(vcnt), 32'd1);
            check("step_latency", 32'(vat), 32'(AC + 2));
        end
    endtask

    // Full scan with button noise; checks order, count and scan_done timing
    task automatic run_scan();
        int exp_idx;
        int done_cnt;
        int done_at;
        int last_v;
        int sum;
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        exp_idx = 0; done_cnt = 0; done_at = -100; last_v = -100; sum = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (data_valid) begin
                check("scan_addr", 32'(chip.address_line), 32'(exp_idx));
                check("scan_data", 32'(data_line), 32'(rom_data(exp_idx)));
                sum = sum + int'(rom_data(exp_idx));
                exp_idx++;
                last_v = cyc;
            end
            if (scan_done) begin
                done_cnt++;
                done_at = cyc;
`ifdef ROM_READER_CHECKSUM_EN
                check("scan_checksum_model", 32'(checksum), 32'(sum));
                check("scan_checksum_const", 32'(checksum), 32'h0FF00);
`endif
            end
            if (exp_idx > 2 && exp_idx < DEPTH) begin
                inc = 1'($urandom_range(0, 1));
                dec = 1'($urandom_range(0, 1));
            end else begin
                inc = 1'b0;
                dec = 1'b0;
            end
            if (done_cnt > 0 && cyc > done_at + 4) break;
            @(negedge clk);
        end
        inc = 1'b0;
        dec = 1'b0;
        check("scan_valid_count", 32'(exp_idx), 32'(DEPTH));
        check("scan_done_count", 32'(done_cnt), 32'd1);
        check("scan_done_latency", 32'(done_at - last_v), 32'd1);
        check("scan_end_addr", 32'(chip.address_line), 32'(DEPTH - 1));
        check("scan_end_busy", 32'(busy), 32'h0);
        model_addr = DEPTH - 1;
    endtask

    initial begin
        int kind;
        int found;
        int dcnt;
`ifdef ROM_READER_CHECKSUM_EN
        logic [DW+AW-1:0] saved_sum;
`endif
        tbl[0] = '{1, 9'h1FF, 8'h5A};
        tbl[1] = '{0, 9'h000, 8'hA5};
        tbl[2] = '{0, 9'h001, 8'hA4};
        tbl[3] = '{2, 9'h001, 8'hA4};
        tbl[4] = '{1, 9'h000, 8'hA5};
        tbl[5] = '{0, 9'h001, 8'hA4};

        repeat (3) @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            do_step(tbl[i].kind, tbl[i].exp_addr, tbl[i].exp_data, 2);
        end
        model_addr = 1;

        // Random manual walk against the address model
        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 1));
            if (kind == 0) model_addr = (model_addr + 1) % DEPTH;
            else model_addr = (model_addr + DEPTH - 1) % DEPTH;
            do_step(kind, AW'(model_addr), rom_data(model_addr), int'($urandom_range(1, 4)));
        end

        run_scan();

`ifdef ROM_READER_CHECKSUM_EN
        saved_sum = checksum;
        do_step(0, 9'h000, 8'hA5, 2);
        check("checksum_after_manual", 32'(checksum), 32'(saved_sum));
        check("checksum_after_manual_const", 32'(checksum), 32'h0FF00);
`endif

        // Reset in the middle of a scan at address 100
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        found = 0;
        dcnt = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (scan_done) dcnt++;
            if (chip.address_line == 9'd100 && busy) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("midscan_reached_100", 32'(found), 32'd1);
        check("midscan_no_done_before", 32'(dcnt), 32'd0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
